// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM encoding, MMIO map
// and the request-beat bundle that gets muxed onto the memory bus.
package dmem_pkg;

  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  localparam logic [31:0] MMIO_LED_ADDR = 32'h4000_000C;
  localparam logic [31:0] MMIO_BCD_ADDR = 32'h4000_0010;

  localparam int WAIT_W = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  function automatic beat_t pick_beat(input logic sel_m1, input beat_t b0, input beat_t b1);
    beat_t res;
    if (sel_m1) begin
      res = b1;
    end else begin
      res = b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive cycles M1 has lost arbitration to M0.
module arb_starve_cnt
  import dmem_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  logic [WAIT_W-1:0] cnt_r;

  // clear has priority over increment; count parks at MAX_WAIT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= {WAIT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {WAIT_W{1'b0}};
    end else if (inc && !at_max) begin
      cnt_r <= cnt_r + WAIT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign at_max = (cnt_r == WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-master arbiter for the single-port data memory: M0 (pipeline MEM stage)
// has priority, M1 (loader/DMA) gets bursts and a starvation guarantee.
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_last,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  localparam int BEAT_W = $clog2(BURST_MAX + 1);

  logic [0:0]        state_r, state_nxt_s;
  logic [BEAT_W-1:0] beat_cnt_r, beat_cnt_nxt_s;
  logic              m0_first_r, m0_first_nxt_s;
  logic              gnt0_s, gnt1_s, wait_clr_s, wait_inc_s, wait_at_max_s;
  logic              any_gnt_s;
  beat_t             bus_s;

  arb_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk    (clk),
    .reset  (reset),
    .clr    (wait_clr_s),
    .inc    (wait_inc_s),
    .at_max (wait_at_max_s)
  );

  // grant decision and next-state; m0_first_r gives M0 the cycle after a length-capped burst
  always_comb begin
    state_nxt_s    = state_r;
    beat_cnt_nxt_s = beat_cnt_r;
    m0_first_nxt_s = m0_first_r;
    gnt0_s         = 1'b0;
    gnt1_s         = 1'b0;
    wait_clr_s     = 1'b0;
    wait_inc_s     = 1'b0;
    case (state_r)
      ST_ARB: begin
        m0_first_nxt_s = 1'b0;
        if (m0_req && m1_req) begin
          if (m0_first_r) begin
            gnt0_s = 1'b1;
          end else if (wait_at_max_s) begin
            gnt1_s     = 1'b1;
            wait_clr_s = 1'b1;
          end else begin
            gnt0_s     = 1'b1;
            wait_inc_s = 1'b1;
          end
        end else if (m0_req) begin
          gnt0_s     = 1'b1;
          wait_clr_s = 1'b1;
        end else if (m1_req) begin
          gnt1_s     = 1'b1;
          wait_clr_s = 1'b1;
        end else begin
          wait_clr_s = 1'b0;
        end
        if (gnt1_s && !m1_last) begin
          state_nxt_s    = ST_BURST;
          beat_cnt_nxt_s = BEAT_W'(1);
        end else begin
          state_nxt_s = ST_ARB;
        end
      end
      ST_BURST: begin
        if (m1_req) begin
          gnt1_s         = 1'b1;
          beat_cnt_nxt_s = beat_cnt_r + BEAT_W'(1);
          if (m1_last) begin
            state_nxt_s = ST_ARB;
          end else if (beat_cnt_r == BEAT_W'(BURST_MAX - 1)) begin
            state_nxt_s    = ST_ARB;
            m0_first_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_BURST;
          end
        end else begin
          state_nxt_s = ST_ARB;
        end
      end
      default: begin
        state_nxt_s = ST_ARB;
      end
    endcase
  end

  // grants are masked while reset is held so nothing reaches memory
  assign m0_gnt    = gnt0_s & reset;
  assign m1_gnt    = gnt1_s & reset;
  assign any_gnt_s = m0_gnt | m1_gnt;
  assign bus_s     = pick_beat(m1_gnt, beat_t'({m0_we, m0_addr, m0_wdata}),
                               beat_t'({m1_we, m1_addr, m1_wdata}));
  assign mem_addr  = any_gnt_s ? bus_s.addr  : 32'h0000_0000;
  assign mem_wdata = any_gnt_s ? bus_s.wdata : 32'h0000_0000;
  assign mem_read  = any_gnt_s & ~bus_s.we;
  assign mem_write = any_gnt_s & bus_s.we;

  // FSM state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_ARB;
      beat_cnt_r <= {BEAT_W{1'b0}};
      m0_first_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      beat_cnt_r <= beat_cnt_nxt_s;
      m0_first_r <= m0_first_nxt_s;
    end
  end

  // read return: capture memory data on a granted read, rdata holds until the next one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m0_rvalid <= 1'b0;
      m0_rdata  <= 32'h0000_0000;
      m1_rvalid <= 1'b0;
      m1_rdata  <= 32'h0000_0000;
    end else begin
      m0_rvalid <= m0_gnt & ~m0_we;
      m1_rvalid <= m1_gnt & ~m1_we;
      if (m0_gnt && !m0_we) begin
        m0_rdata <= mem_rdata;
      end else begin
        m0_rdata <= m0_rdata;
      end
      if (m1_gnt && !m1_we) begin
        m1_rdata <= mem_rdata;
      end else begin
        m1_rdata <= m1_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small RAM + LED/BCD MMIO model.
module tb_dmem_port_arbiter;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we, m1_last;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  logic [31:0] ram [0:255];
  logic [31:0] led_data, bcd_data;
  int          n_checks = 0;
  int          n_errors = 0;
  int          m1_gnt_cnt;

  dmem_port_arbiter #(.MAX_WAIT(4), .BURST_MAX(8)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_last(m1_last), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr[9:2]];

  // memory model: preloaded while reset is low, MMIO writes land in LED/BCD registers
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h0000_0000;
      ram[0]   <= 32'h6463_6261;
      led_data <= 32'h0000_0000;
      bcd_data <= 32'h0000_0000;
    end else if (mem_write) begin
      if (mem_addr == MMIO_LED_ADDR) led_data <= mem_wdata;
      else if (mem_addr == MMIO_BCD_ADDR) bcd_data <= mem_wdata;
      else ram[mem_addr[9:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0; m1_wdata = 32'h0; m1_last = 1'b0;

    // 1: reset held with both masters requesting
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("rst_m0_gnt", {31'h0, m0_gnt}, 32'h0);
      chk("rst_m1_gnt", {31'h0, m1_gnt}, 32'h0);
      chk("rst_mem_write", {31'h0, mem_write}, 32'h0);
      chk("rst_rvalid", {30'h0, m0_rvalid, m1_rvalid}, 32'h0);
    end
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    m0_req = 1'b0; m1_req = 1'b0;
    reset = 1'b1;
    tick();

    // 2: lone M0 read
    tick(); m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0; #1;
    chk("rd_m0_gnt", {31'h0, m0_gnt}, 32'h1);
    chk("rd_mem_read", {31'h0, mem_read}, 32'h1);
    tick(); m0_req = 1'b0; #1;
    chk("rd_m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
    chk("rd_m0_rdata", m0_rdata, 32'h6463_6261);
    tick(); #1;
    chk("rd_rvalid_drop", {31'h0, m0_rvalid}, 32'h0);
    chk("rd_rdata_hold", m0_rdata, 32'h6463_6261);

    // 3: both requesting continuously -> M0 x4 then M1
    m1_we = 1'b1; m1_addr = 32'h40; m1_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(); m0_req = 1'b1; m1_req = 1'b1; m1_wdata = i; #1;
      chk($sformatf("fair_m0_%0d", i), {31'h0, m0_gnt}, (i % 5 == 4) ? 32'h0 : 32'h1);
      chk($sformatf("fair_m1_%0d", i), {31'h0, m1_gnt}, (i % 5 == 4) ? 32'h1 : 32'h0);
    end
    tick(); m0_req = 1'b0; m1_req = 1'b0;

    // 4: 3-beat M1 write burst, M0 locked out until it ends
    tick(); m1_req = 1'b1; m1_we = 1'b1; m1_last = 1'b0;
    m1_addr = 32'h10; m1_wdata = 32'h1111_1111; #1;
    chk("b3_beat1_gnt", {31'h0, m1_gnt}, 32'h1);
    chk("b3_beat1_addr", mem_addr, 32'h10);
    chk("b3_beat1_write", {31'h0, mem_write}, 32'h1);
    tick(); m0_req = 1'b1; m1_addr = 32'h14; m1_wdata = 32'h2222_2222; #1;
    chk("b3_beat2_m1", {31'h0, m1_gnt}, 32'h1);
    chk("b3_beat2_m0", {31'h0, m0_gnt}, 32'h0);
    chk("b3_beat2_wdata", mem_wdata, 32'h2222_2222);
    tick(); m1_addr = 32'h18; m1_wdata = 32'h3333_3333; m1_last = 1'b1; #1;
    chk("b3_beat3_m1", {31'h0, m1_gnt}, 32'h1);
    chk("b3_beat3_m0", {31'h0, m0_gnt}, 32'h0);
    tick(); m1_req = 1'b0; m1_last = 1'b0; #1;
    chk("b3_after_m0", {31'h0, m0_gnt}, 32'h1);
    chk("b3_after_m1", {31'h0, m1_gnt}, 32'h0);
    tick(); m0_req = 1'b0; #1;
    chk("b3_ram_0x10", ram[4], 32'h1111_1111);
    chk("b3_ram_0x18", ram[6], 32'h3333_3333);

    // 5: unterminated M1 read burst capped at 8 beats, M0 slips in, M1 resumes
    m1_gnt_cnt = 0;
    tick(); m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0; m1_last = 1'b0; #1;
    chk("cap_beat1", {31'h0, m1_gnt}, 32'h1);
    m1_gnt_cnt += int'(m1_gnt);
    for (int i = 2; i <= 8; i++) begin
      tick(); m0_req = 1'b1; #1;
      chk($sformatf("cap_beat%0d_m1", i), {31'h0, m1_gnt}, 32'h1);
      chk($sformatf("cap_beat%0d_m0", i), {31'h0, m0_gnt}, 32'h0);
      m1_gnt_cnt += int'(m1_gnt);
    end
    tick(); #1;
    chk("cap_m0_slot", {31'h0, m0_gnt}, 32'h1);
    chk("cap_m1_blocked", {31'h0, m1_gnt}, 32'h0);
    chk("cap_m1_rvalid", {31'h0, m1_rvalid}, 32'h1);
    chk("cap_m1_rdata", m1_rdata, 32'h6463_6261);
    m1_gnt_cnt += int'(m1_gnt);
    chk("cap_beat_count", m1_gnt_cnt, 32'd8);
    tick(); m0_req = 1'b0; #1;
    chk("cap_m1_resume", {31'h0, m1_gnt}, 32'h1);
    tick(); m1_req = 1'b0;
    tick();

    // 6: MMIO LED write, then reset in the middle of a burst
    tick(); m0_req = 1'b1; m0_we = 1'b1; m0_addr = MMIO_LED_ADDR; m0_wdata = 32'h0000_00A5; #1;
    chk("led_gnt", {31'h0, m0_gnt}, 32'h1);
    chk("led_mem_write", {31'h0, mem_write}, 32'h1);
    chk("led_mem_addr", mem_addr, 32'h4000_000C);
    tick(); m0_req = 1'b0; m0_we = 1'b0; #1;
    chk("led_write_once", {31'h0, mem_write}, 32'h0);
    chk("led_data", led_data, 32'h0000_00A5);
    tick(); m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h10; m1_last = 1'b0; #1;
    chk("mid_beat1", {31'h0, m1_gnt}, 32'h1);
    tick(); #1;
    chk("mid_beat2", {31'h0, m1_gnt}, 32'h1);
    chk("mid_rvalid", {31'h0, m1_rvalid}, 32'h1);
    tick(); reset = 1'b0; #1;
    chk("mid_rst_gnt", {31'h0, m1_gnt}, 32'h0);
    chk("mid_rst_rvalid", {31'h0, m1_rvalid}, 32'h0);
    chk("mid_rst_rdata", m1_rdata, 32'h0);
    chk("mid_rst_read", {31'h0, mem_read}, 32'h0);
    tick();
    tick(); reset = 1'b1; m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0; #1;
    chk("post_rst_m0", {31'h0, m0_gnt}, 32'h1);
    chk("post_rst_m1", {31'h0, m1_gnt}, 32'h0);
    tick(); m0_req = 1'b0; m1_req = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
